krnl_cam_rtl_cmd_issuer: RTL and testbench

// Command-issue side of the CAM control interface: accepts CAM operations from the kernel

---
 rtl/krnl_cam_pkg.sv | 26 ++
 rtl/krnl_cam_rtl_cmd_fifo.sv | 64 ++++++
 rtl/krnl_cam_rtl_cmd_issuer.sv | 149 ++++++++++++++
 tb/tb_krnl_cam_rtl_cmd_issuer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_cam_pkg.sv
// rtl/krnl_cam_pkg.sv - shared opcodes, field positions and enums for the CAM command issuer
package krnl_cam_pkg;

    localparam int CAM_IDLE        = 0;
    localparam int CAM_UPDATE_ALL  = 1;
    localparam int CAM_SEARCH      = 2;
    localparam int CAM_UPDATE_ONE  = 3;

    localparam int COMPARE_NUM_LSB = 32;
    localparam int COMPARE_NUM_MSB = 63;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_ACCEPT = 2'd1,
        S_WAIT_DONE   = 2'd2,
        S_REPORT      = 2'd3
    } issuer_state_e;

    typedef enum logic [1:0] {
        ST_OK             = 2'd0,
        ST_INVALID_OP     = 2'd1,
        ST_ACCEPT_TIMEOUT = 2'd2,
        ST_DONE_TIMEOUT   = 2'd3
    } done_status_e;

endpackage

// File: rtl/krnl_cam_rtl_cmd_fifo.sv
// rtl/krnl_cam_rtl_cmd_fifo.sv - command queue of {op, compare_num} entries
module krnl_cam_rtl_cmd_fifo #(
    parameter int OP_W  = 3,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [OP_W-1:0] i_op,
    input  logic [31:0]     i_num,
    input  logic            i_pop,
    output logic [OP_W-1:0] o_op,
    output logic [31:0]     o_num,
    output logic            o_full,
    output logic            o_not_empty,
    output logic            o_head_valid
);
    localparam int AW = $clog2(DEPTH);

    logic [OP_W+31:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_was_empty;
    logic             w_push;
    logic             w_pop;

    assign o_full       = (r_count == (AW+1)'(DEPTH));
    assign o_not_empty  = (r_count != '0);
    // An entry written into an empty queue is hidden for one cycle (no bypass to the issuer).
    assign o_head_valid = o_not_empty && !r_was_empty;
    assign w_push       = i_push && !o_full;
    assign w_pop        = i_pop && o_not_empty;
    assign {o_op, o_num} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_op, i_num};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_was_empty <= 1'b1;
        end else begin
            r_was_empty <= (r_count == '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/krnl_cam_rtl_cmd_issuer.sv
// rtl/krnl_cam_rtl_cmd_issuer.sv - queues CAM ops, issues command words one at a time, reports completion
module krnl_cam_rtl_cmd_issuer
    import krnl_cam_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 512,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OP_CODE_WIDTH-1:0] cmd_op,
    input  logic [31:0]              cmd_compare_num,
    output logic [C_DATA_WIDTH-1:0]  data_out,
    input  logic [OP_CODE_WIDTH-1:0] cam_state,
    output logic                     done_valid,
    output logic [OP_CODE_WIDTH-1:0] done_op,
    output logic [1:0]               done_status,
    output logic [31:0]              done_cycles,
    output logic                     busy
);
    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

    issuer_state_e              r_state;
    done_status_e               r_status;
    logic [C_DATA_WIDTH-1:0]    r_data_out;
    logic [OP_CODE_WIDTH-1:0]   r_cur_op;
    logic [31:0]                r_cnt;
    logic                       r_done_valid;
    logic [OP_CODE_WIDTH-1:0]   r_done_op;
    done_status_e               r_done_status;
    logic [31:0]                r_done_cycles;

    logic                       w_full;
    logic                       w_not_empty;
    logic                       w_head_valid;
    logic [OP_CODE_WIDTH-1:0]   w_head_op;
    logic [31:0]                w_head_num;
    logic                       w_pop;
    logic                       w_valid_op;
    logic                       w_cam_idle;
    logic [31:0]                w_cnt_inc;
    logic [C_DATA_WIDTH-1:0]    w_word;

    krnl_cam_rtl_cmd_fifo #(
        .OP_W  (OP_CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (cmd_valid),
        .i_op         (cmd_op),
        .i_num        (cmd_compare_num),
        .i_pop        (w_pop),
        .o_op         (w_head_op),
        .o_num        (w_head_num),
        .o_full       (w_full),
        .o_not_empty  (w_not_empty),
        .o_head_valid (w_head_valid)
    );

    assign cmd_ready   = !w_full;
    assign busy        = w_not_empty || (r_state != S_IDLE);
    assign data_out    = r_data_out;
    assign done_valid  = r_done_valid;
    assign done_op     = r_done_op;
    assign done_status = r_done_status;
    assign done_cycles = r_done_cycles;

    assign w_cam_idle = (cam_state == OP_CODE_WIDTH'(CAM_IDLE));
    // The CAM may be busy on behalf of another master, so only pop while it is idle.
    assign w_pop      = (r_state == S_IDLE) && w_head_valid && w_cam_idle;
    assign w_valid_op = (w_head_op == OP_CODE_WIDTH'(CAM_UPDATE_ALL)) ||
                        (w_head_op == OP_CODE_WIDTH'(CAM_SEARCH)) ||
                        (w_head_op == OP_CODE_WIDTH'(CAM_UPDATE_ONE));
    assign w_cnt_inc  = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

    always_comb begin
        w_word            = '0;
        w_word[w_head_op] = 1'b1;
        if (w_head_op == OP_CODE_WIDTH'(CAM_SEARCH)) begin
            w_word[COMPARE_NUM_MSB:COMPARE_NUM_LSB] = w_head_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_status      <= ST_OK;
            r_data_out    <= '0;
            r_cur_op      <= '0;
            r_cnt         <= '0;
            r_done_valid  <= 1'b0;
            r_done_op     <= '0;
            r_done_status <= ST_OK;
            r_done_cycles <= '0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur_op <= w_head_op;
                        r_cnt    <= '0;
                        if (w_valid_op) begin
                            r_data_out <= w_word;
                            r_state    <= S_WAIT_ACCEPT;
                        end else begin
                            r_status <= ST_INVALID_OP;
                            r_state  <= S_REPORT;
                        end
                    end
                end
                S_WAIT_ACCEPT: begin
                    r_cnt <= w_cnt_inc;
                    // Any non-idle CAM state counts as acceptance; decode priority is the CAM's concern.
                    if (!w_cam_idle) begin
                        r_data_out <= '0;
                        r_state    <= S_WAIT_DONE;
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_data_out <= '0;
                        r_status   <= ST_ACCEPT_TIMEOUT;
                        r_state    <= S_REPORT;
                    end
                end
                S_WAIT_DONE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cam_idle) begin
                        r_status <= ST_OK;
                        r_state  <= S_REPORT;
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_status <= ST_DONE_TIMEOUT;
                        r_state  <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_done_valid  <= 1'b1;
                    r_done_op     <= r_cur_op;
                    r_done_status <= r_status;
                    r_done_cycles <= r_cnt;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_krnl_cam_rtl_cmd_issuer.sv
// tb/tb_krnl_cam_rtl_cmd_issuer.sv - scoreboard bench for the CAM command issuer
module tb_krnl_cam_rtl_cmd_issuer;
    localparam int DW  = 128;
    localparam int OPW = 3;
    localparam int TO  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op = '0;
    logic [31:0]    cmd_compare_num = '0;
    logic [DW-1:0]  data_out;
    logic [OPW-1:0] cam_state;
    logic           done_valid;
    logic [OPW-1:0] done_op;
    logic [1:0]     done_status;
    logic [31:0]    done_cycles;
    logic           busy;

    logic           ext_busy = 1'b1;
    logic           cam_dead = 1'b0;
    logic [OPW-1:0] model_state = '0;
    int             rem = 0;
    int             dur = 5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [OPW-1:0] op;
        logic [1:0]     st;
        int             cyc;
    } done_t;

    done_t         exp_done[$];
    logic [DW-1:0] exp_word[$];
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    assign cam_state = ext_busy ? 3'd1 : model_state;

    krnl_cam_rtl_cmd_issuer #(
        .C_DATA_WIDTH   (DW),
        .OP_CODE_WIDTH  (OPW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_compare_num (cmd_compare_num),
        .data_out        (data_out),
        .cam_state       (cam_state),
        .done_valid      (done_valid),
        .done_op         (done_op),
        .done_status     (done_status),
        .done_cycles     (done_cycles),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CAM model: takes the command in the same cycle it appears, stays busy for dur cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_state = '0;
            rem = 0;
        end else if (model_state != '0) begin
            rem--;
            if (rem <= 0) model_state = '0;
        end else if (data_out != '0 && !ext_busy && !cam_dead) begin
            model_state = data_out[1] ? 3'd1 : (data_out[2] ? 3'd2 : 3'd3);
            rem = dur;
        end
    end

    // Monitor: issued command words.
    always @(negedge clk) begin
        if (data_out != '0 && prev_data == '0) begin
            if (exp_word.size() == 0) begin
                chk("unexpected_issue", data_out, '0);
            end else begin
                chk("issue_word", data_out, exp_word.pop_front());
            end
        end
        prev_data = data_out;
    end

    // Monitor: completion records.
    always @(negedge clk) begin
        if (done_valid) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", done_valid, 1'b0);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                chk("done_op", done_op, d.op);
                chk("done_status", done_status, d.st);
                if (d.cyc >= 0) chk("done_cycles", done_cycles, d.cyc);
            end
        end
    end

    task automatic push(input logic [OPW-1:0] op, input logic [31:0] num,
                        input logic [DW-1:0] word, input logic [1:0] st, input int cyc);
        done_t d;
        bit    got;
        bit    rdy;
        got   = 1'b0;
        d.op  = op;
        d.st  = st;
        d.cyc = cyc;
        if (word != '0) exp_word.push_back(word);
        exp_done.push_back(d);
        cmd_valid       = 1'b1;
        cmd_op          = op;
        cmd_compare_num = num;
        for (int i = 0; i < 300; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!got) chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (!busy && cam_state == '0 && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle", ok, 1'b1);
    endtask

    task automatic wait_done(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_done", ok, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, '0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_status", done_status, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;

        // CAM busy from another master at reset release; fill the queue.
        dur = 3;
        push(3'd2, 32'h11, 128'h11_0000_0004, 2'd0, 4);
        push(3'd1, 32'h99, 128'h2, 2'd0, 4);
        push(3'd2, 32'h22, 128'h22_0000_0004, 2'd0, 4);
        push(3'd3, 32'h0, 128'h8, 2'd0, 4);
        chk("ready_low_full", cmd_ready, 1'b0);
        chk("busy_queued", busy, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("no_issue_cam_busy", data_out, '0);
        end
        ext_busy = 1'b0;
        push(3'd2, 32'h33, 128'h33_0000_0004, 2'd0, 4);
        wait_idle(300);

        // Single SEARCH: latency and one-cycle command word.
        dur = 20;
        push(3'd2, 32'h10, 128'h10_0000_0004, 2'd0, 21);
        @(posedge clk); #1;
        chk("lat_edge_n1", data_out, '0);
        @(posedge clk); #1;
        chk("lat_edge_n2", data_out, 128'h10_0000_0004);
        @(posedge clk); #1;
        chk("word_one_cycle", data_out, '0);
        wait_idle(100);

        // Invalid opcode.
        push(3'd5, 32'h77, '0, 2'd1, -1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("inv_no_early_done", done_valid, 1'b0);
        end
        @(posedge clk); #1;
        chk("inv_done_pulse", done_valid, 1'b1);
        chk("inv_status", done_status, 2'd1);
        @(posedge clk); #1;
        chk("done_pulse_width", done_valid, 1'b0);
        chk("status_held", done_status, 2'd1);
        wait_idle(50);

        // CAM never accepts: accept timeout, then the next queued command issues.
        cam_dead = 1'b1;
        dur = 4;
        push(3'd1, 32'h0, 128'h2, 2'd2, -1);
        push(3'd2, 32'hA5, 128'hA5_0000_0004, 2'd0, 5);
        wait_done(100);
        chk("ato_status", done_status, 2'd2);
        chk("ato_data_cleared", data_out, '0);
        cam_dead = 1'b0;
        wait_idle(200);

        // CAM accepts but stays busy past the timeout.
        dur = 40;
        push(3'd3, 32'h0, 128'h8, 2'd3, -1);
        wait_idle(200);

        // Reset while waiting for completion.
        dur = 30;
        push(3'd2, 32'h5A, 128'h5A_0000_0004, 2'd0, 31);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", data_out, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_done_valid", done_valid, 1'b0);
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 1'b0);

        chk("words_outstanding", exp_word.size(), 0);
        chk("dones_outstanding", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
